// File: rtl/fetch_queue_pkg.sv
// Y86 fetch-to-decode queue shared definitions: instruction codes, status codes,
// register ids and the layout of the nibble part of a queued record.
package fetch_queue_pkg;

   localparam int NIB_W = 4;
   localparam int WORD_W_DEFAULT = 64;

   // Instruction codes
   localparam logic [NIB_W-1:0] IHALT   = 4'h0;
   localparam logic [NIB_W-1:0] INOP    = 4'h1;
   localparam logic [NIB_W-1:0] IRRMOVQ = 4'h2;
   localparam logic [NIB_W-1:0] IIRMOVQ = 4'h3;
   localparam logic [NIB_W-1:0] IRMMOVQ = 4'h4;
   localparam logic [NIB_W-1:0] IMRMOVQ = 4'h5;
   localparam logic [NIB_W-1:0] IOPQ    = 4'h6;
   localparam logic [NIB_W-1:0] IJXX    = 4'h7;
   localparam logic [NIB_W-1:0] ICALL   = 4'h8;
   localparam logic [NIB_W-1:0] IRET    = 4'h9;
   localparam logic [NIB_W-1:0] IPUSHQ  = 4'hA;
   localparam logic [NIB_W-1:0] IPOPQ   = 4'hB;

   // Status codes
   localparam logic [NIB_W-1:0] SBUB = 4'h0;
   localparam logic [NIB_W-1:0] SAOK = 4'h1;
   localparam logic [NIB_W-1:0] SADR = 4'h2;
   localparam logic [NIB_W-1:0] SINS = 4'h3;
   localparam logic [NIB_W-1:0] SHLT = 4'h4;

   localparam logic [NIB_W-1:0] RNONE = 4'hF;

   typedef struct packed {
      logic [NIB_W-1:0] icode;
      logic [NIB_W-1:0] ifun;
      logic [NIB_W-1:0] ra;
      logic [NIB_W-1:0] rb;
      logic [NIB_W-1:0] stat;
   } fq_nib_t;

   localparam int NIB_REC_W = $bits(fq_nib_t);

   // Nibble fields decode sees when no real record is at the head.
   function automatic fq_nib_t bubble_nib();
      fq_nib_t b;
      b.icode = INOP;
      b.ifun  = '0;
      b.ra    = RNONE;
      b.rb    = RNONE;
      b.stat  = SBUB;
      return b;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Record storage: DEPTH x WIDTH register array, one synchronous write port and
// one combinational read port; no reset, no backpressure of its own.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 148
) (
   input  logic                     clk_i,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_dat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode record queue; head appears one cycle after push (no fall-through).
// Backpressure: f_ready_o drops when full or after a non-SAOK record is accepted; flush empties it.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 64
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,

   input  logic                     f_valid_i,
   output logic                     f_ready_o,
   input  logic [3:0]               f_icode_i,
   input  logic [3:0]               f_ifun_i,
   input  logic [3:0]               f_rA_i,
   input  logic [3:0]               f_rB_i,
   input  logic [3:0]               f_stat_i,
   input  logic [WORD_W-1:0]        f_valC_i,
   input  logic [WORD_W-1:0]        f_valP_i,

   input  logic                     flush_i,

   input  logic                     D_ready_i,
   output logic                     D_valid_o,
   output logic [3:0]               D_icode_o,
   output logic [3:0]               D_ifun_o,
   output logic [3:0]               D_rA_o,
   output logic [3:0]               D_rB_o,
   output logic [3:0]               D_stat_o,
   output logic [WORD_W-1:0]        D_valC_o,
   output logic [WORD_W-1:0]        D_valP_o,

   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     halted_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int REC_W = NIB_REC_W + 2 * WORD_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             halted;

   logic             push;
   logic             pop;
   fq_nib_t          w_nib;
   fq_nib_t          r_nib;
   logic [REC_W-1:0] w_rec;
   logic [REC_W-1:0] r_rec;

   // Handshakes depend only on registered state so fetch never sees a comb path from decode.
   assign f_ready_o = (count != FULL_CNT) && !halted;
   assign D_valid_o = (count != '0);
   assign count_o   = count;
   assign halted_o  = halted;

   assign push = f_valid_i && f_ready_o && !flush_i;
   assign pop  = D_ready_i && D_valid_o && !flush_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         halted <= 1'b0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         halted <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Records behind a faulting one must not enter; those ahead keep draining.
         if (push && (f_stat_i != SAOK)) begin
            halted <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nib       = '0;
      w_nib.icode = f_icode_i;
      w_nib.ifun  = f_ifun_i;
      w_nib.ra    = f_rA_i;
      w_nib.rb    = f_rB_i;
      w_nib.stat  = f_stat_i;
   end

   assign w_rec = {w_nib, f_valC_i, f_valP_i};

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_mem (
      .clk_i   (clk_i),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_dat  (w_rec),
      .rd_addr (rd_ptr),
      .rd_dat  (r_rec)
   );

   assign r_nib = r_rec[REC_W-1 -: NIB_REC_W];

   always_comb begin
      fq_nib_t b;
      b         = bubble_nib();
      D_icode_o = b.icode;
      D_ifun_o  = b.ifun;
      D_rA_o    = b.ra;
      D_rB_o    = b.rb;
      D_stat_o  = b.stat;
      D_valC_o  = '0;
      D_valP_o  = '0;
      if (D_valid_o) begin
         D_icode_o = r_nib.icode;
         D_ifun_o  = r_nib.ifun;
         D_rA_o    = r_nib.ra;
         D_rB_o    = r_nib.rb;
         D_stat_o  = r_nib.stat;
         D_valC_o  = r_rec[2*WORD_W-1 -: WORD_W];
         D_valP_o  = r_rec[WORD_W-1:0];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table of push/pop vectors plus hand-written
// sequences for flush, halt, and asynchronous reset.
module tb_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int WORD_W = 64;

   logic              clk = 1'b0;
   logic              rstn;
   logic              f_valid;
   logic              f_ready;
   logic [3:0]        f_icode, f_ifun, f_ra, f_rb, f_stat;
   logic [WORD_W-1:0] f_valc, f_valp;
   logic              flush;
   logic              d_ready;
   logic              d_valid;
   logic [3:0]        d_icode, d_ifun, d_ra, d_rb, d_stat;
   logic [WORD_W-1:0] d_valc, d_valp;
   logic [2:0]        count;
   logic              halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        fv;
      logic [63:0] valp;
      logic        dr;
      logic [2:0]  exp_cnt;
      logic        exp_dv;
      logic        exp_fr;
      logic [63:0] exp_valp;
   } vec_t;

   vec_t tbl[$];

   fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .f_valid_i (f_valid),
      .f_ready_o (f_ready),
      .f_icode_i (f_icode),
      .f_ifun_i  (f_ifun),
      .f_rA_i    (f_ra),
      .f_rB_i    (f_rb),
      .f_stat_i  (f_stat),
      .f_valC_i  (f_valc),
      .f_valP_i  (f_valp),
      .flush_i   (flush),
      .D_ready_i (d_ready),
      .D_valid_o (d_valid),
      .D_icode_o (d_icode),
      .D_ifun_o  (d_ifun),
      .D_rA_o    (d_ra),
      .D_rB_o    (d_rb),
      .D_stat_o  (d_stat),
      .D_valC_o  (d_valc),
      .D_valP_o  (d_valp),
      .count_o   (count),
      .halted_o  (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [3:0] icode, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] stat, input logic [63:0] valp,
                        input logic dr, input logic fl);
      f_valid = fv;
      f_icode = icode;
      f_ifun  = 4'h0;
      f_ra    = ra;
      f_rb    = rb;
      f_stat  = stat;
      f_valp  = valp;
      f_valc  = ~valp;
      d_ready = dr;
      flush   = fl;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, " dvalid"}, 64'(d_valid), 64'h0);
      check({tag, " icode"},  64'(d_icode), 64'h1);
      check({tag, " ifun"},   64'(d_ifun),  64'h0);
      check({tag, " rA"},     64'(d_ra),    64'hF);
      check({tag, " rB"},     64'(d_rb),    64'hF);
      check({tag, " stat"},   64'(d_stat),  64'h0);
      check({tag, " valC"},   d_valc,       64'h0);
      check({tag, " valP"},   d_valp,       64'h0);
   endtask

   task automatic add(input logic fv, input logic [63:0] valp, input logic dr,
                      input logic [2:0] cnt, input logic dv, input logic fr,
                      input logic [63:0] evalp);
      vec_t v;
      v.fv = fv; v.valp = valp; v.dr = dr;
      v.exp_cnt = cnt; v.exp_dv = dv; v.exp_fr = fr; v.exp_valp = evalp;
      tbl.push_back(v);
   endtask

   initial begin
      // Fill to capacity, refuse the 5th, then drain in order while the 5th enters.
      add(1'b1, 64'h1, 1'b0, 3'd1, 1'b1, 1'b1, 64'h1);
      add(1'b1, 64'h2, 1'b0, 3'd2, 1'b1, 1'b1, 64'h1);
      add(1'b1, 64'h3, 1'b0, 3'd3, 1'b1, 1'b1, 64'h1);
      add(1'b1, 64'h4, 1'b0, 3'd4, 1'b1, 1'b0, 64'h1);
      add(1'b1, 64'h5, 1'b0, 3'd4, 1'b1, 1'b0, 64'h1);
      add(1'b1, 64'h5, 1'b1, 3'd3, 1'b1, 1'b1, 64'h2);
      add(1'b1, 64'h5, 1'b1, 3'd3, 1'b1, 1'b1, 64'h3);
      add(1'b0, 64'h0, 1'b1, 3'd2, 1'b1, 1'b1, 64'h4);
      add(1'b0, 64'h0, 1'b1, 3'd1, 1'b1, 1'b1, 64'h5);
      add(1'b0, 64'h0, 1'b1, 3'd0, 1'b0, 1'b1, 64'h0);
      // Streaming: occupancy stays at one while pointers wrap.
      add(1'b1, 64'h10, 1'b0, 3'd1, 1'b1, 1'b1, 64'h10);
      for (int i = 1; i < 10; i++) begin
         add(1'b1, 64'h10 + 64'(i), 1'b1, 3'd1, 1'b1, 1'b1, 64'h10 + 64'(i));
      end
      add(1'b0, 64'h0, 1'b1, 3'd0, 1'b0, 1'b1, 64'h0);

      idle();
      rstn = 1'b0;
      #1;
      check("reset count", 64'(count), 64'h0);
      check("reset fready", 64'(f_ready), 64'h1);
      check("reset halted", 64'(halted), 64'h0);
      check_bubble("reset");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      // First record appears one cycle after the push.
      drive(1'b1, 4'h2, 4'h0, 4'h3, 4'h1, 64'h2, 1'b0, 1'b0);
      #1;
      check("first push-cycle dvalid", 64'(d_valid), 64'h0);
      tick();
      idle();
      check("first dvalid", 64'(d_valid), 64'h1);
      check("first icode", 64'(d_icode), 64'h2);
      check("first rA", 64'(d_ra), 64'h0);
      check("first rB", 64'(d_rb), 64'h3);
      check("first count", 64'(count), 64'h1);
      check("first valP", d_valp, 64'h2);
      check("first valC", d_valc, ~64'h2);
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0, 1'b1, 1'b0);
      tick();
      check("first drained count", 64'(count), 64'h0);
      check_bubble("first drained");

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].fv, 4'h6, 4'h1, 4'h2, 4'h1, tbl[i].valp, tbl[i].dr, 1'b0);
         tick();
         check($sformatf("vec%0d count", i), 64'(count), 64'(tbl[i].exp_cnt));
         check($sformatf("vec%0d dvalid", i), 64'(d_valid), 64'(tbl[i].exp_dv));
         check($sformatf("vec%0d fready", i), 64'(f_ready), 64'(tbl[i].exp_fr));
         check($sformatf("vec%0d halted", i), 64'(halted), 64'h0);
         check($sformatf("vec%0d valP", i), d_valp, tbl[i].exp_valp);
         check($sformatf("vec%0d icode", i), 64'(d_icode), tbl[i].exp_dv ? 64'h6 : 64'h1);
      end
      idle();

      // Flush with concurrent push and pop: everything, including the push, is dropped.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h31 + 64'(k), 1'b0, 1'b0);
         tick();
      end
      check("flush pre count", 64'(count), 64'h3);
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h34, 1'b1, 1'b1);
      tick();
      idle();
      check("flush count", 64'(count), 64'h0);
      check("flush fready", 64'(f_ready), 64'h1);
      check_bubble("flush");
      tick();
      check("flush push lost", 64'(count), 64'h0);
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h40, 1'b0, 1'b0);
      tick();
      check("post-flush count", 64'(count), 64'h1);
      check("post-flush valP", d_valp, 64'h40);
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0, 1'b1, 1'b0);
      tick();
      check("post-flush drained", 64'(count), 64'h0);

      // Halt: SHLT record closes the queue but drains behind the earlier record.
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h4F, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'h0, 4'hF, 4'hF, 4'h4, 64'h50, 1'b0, 1'b0);
      tick();
      check("halt count", 64'(count), 64'h2);
      check("halt halted", 64'(halted), 64'h1);
      check("halt fready", 64'(f_ready), 64'h0);
      check("halt head valP", d_valp, 64'h4F);
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h51, 1'b1, 1'b0);
      tick();
      check("halt drain count", 64'(count), 64'h1);
      check("halt drain stat", 64'(d_stat), 64'h4);
      check("halt drain icode", 64'(d_icode), 64'h0);
      check("halt drain valP", d_valp, 64'h50);
      check("halt drain halted", 64'(halted), 64'h1);
      tick();
      check("halt empty count", 64'(count), 64'h0);
      check("halt empty halted", 64'(halted), 64'h1);
      check("halt empty fready", 64'(f_ready), 64'h0);
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0, 1'b0, 1'b1);
      tick();
      idle();
      check("halt flush halted", 64'(halted), 64'h0);
      check("halt flush fready", 64'(f_ready), 64'h1);

      // Asynchronous reset between edges.
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h61, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h62, 1'b0, 1'b0);
      tick();
      idle();
      check("arst pre count", 64'(count), 64'h2);
      rstn = 1'b0;
      #2;
      check("arst count", 64'(count), 64'h0);
      check("arst fready", 64'(f_ready), 64'h1);
      check("arst halted", 64'(halted), 64'h0);
      check_bubble("arst");
      rstn = 1'b1;
      tick();
      check("arst after edge count", 64'(count), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter WORD_W, default 64, width of valC and valP.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous and active-low.
REQ-005 f_valid_i  in  1  fetch stage presents a record this cycle.
REQ-006 f_ready_o  out  1  queue accepts a record this cycle.
REQ-007 f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_stat_i  in  4 each  fetched instruction fields.
REQ-008 f_valC_i, f_valP_i  in  WORD_W each  fetched constant and next PC.
REQ-009 flush_i  in  1  redirect (mispredicted branch from M or ret from W); discards all queued records.
REQ-010 D_ready_i  in  1  decode consumes the head record this cycle.
REQ-011 D_valid_o  out  1  head record is real, not a bubble.
REQ-012 D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_stat_o  out  4 each  head record fields.
REQ-013 D_valC_o, D_valP_o  out  WORD_W each  head record constant and next PC.
REQ-014 count_o  out  log2(DEPTH)+1  occupancy.
REQ-015 halted_o  out  1  a non-SAOK record has been accepted and no flush has followed.

Function
REQ-016 Push SHALL occur when f_valid_i and f_ready_o are both high and flush_i is low.
REQ-017 Pop SHALL occur when D_ready_i and D_valid_o are both high and flush_i is low.
REQ-018 f_ready_o SHALL equal (count_o != DEPTH) and not halted_o, derived combinationally from registered state only.
REQ-019 D_valid_o SHALL equal (count_o != 0); head fields SHALL be read from storage, so a record pushed into an empty queue appears one cycle later (no fall-through).
REQ-020 When D_valid_o is low, outputs SHALL be: D_icode_o INOP (1), D_ifun_o 0, D_rA_o and D_rB_o RNONE (F), D_valC_o 0, D_valP_o 0, D_stat_o SBUB (0).
REQ-021 Simultaneous push and pop on a non-empty, non-full queue SHALL leave count_o unchanged and preserve FIFO order.
REQ-022 Pop on a full queue SHALL free one slot, with f_ready_o high next cycle; no push SHALL occur in the same cycle because f_ready_o is low.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Accepting a record with f_stat_i != SAOK (1) SHALL set halted_o on the next edge; earlier records SHALL still drain normally.
REQ-025 flush_i high at an edge SHALL zero both pointers and count_o and clear halted_o; any push or pop in that cycle SHALL be ignored.
REQ-026 D_valid_o SHALL be low and bubble outputs shown in the cycle after a flush.
REQ-027 f_valid_i while f_ready_o is low SHALL have no effect; the fetch stage holds its PC.

Reset
REQ-028 While rstn_i is low: pointers 0, count_o 0, halted_o 0, D_valid_o 0, bubble outputs per REQ-020, f_ready_o 1.
REQ-029 Asserting rstn_i mid-operation SHALL discard all records immediately, without waiting for a clock edge.
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 Icode constants (INOP, IHALT, IOPQ, ...), status codes (SAOK, SADR, SINS, SHLT, SBUB), RNONE and the nibble and word width macros SHALL come from the shared define file.
REQ-032 One sub-module, fetch_queue_mem, SHALL be used: DEPTH x record-width register array with write port and combinational read port, no reset.

Verification
REQ-033 Reset, then push IRRMOVQ (icode 2, rA 0, rB 3, valP 0x2) -> D_valid_o 0 in the push cycle; next cycle D_valid_o 1, D_icode_o 2, D_rB_o 3, count_o 1.
REQ-034 DEPTH=4, D_ready_i 0, push 5 records with valP 1..5 -> f_ready_o 0 after the 4th push, the 5th is not accepted, count_o 4; then D_ready_i 1 -> pops valP 1,2,3,4 in order, and the 5th is accepted once f_ready_o rises.
REQ-035 Continuous push and pop for 10 cycles with valP 0x10..0x19 -> count_o constant at 1, outputs in order, pointers wrap twice.
REQ-036 3 records queued, flush_i together with f_valid_i and D_ready_i high -> next cycle count_o 0, D_stat_o SBUB, D_icode_o INOP; the flush-cycle push is lost.
REQ-037 Push a record with stat SHLT (4) followed by f_valid_i held high -> halted_o 1, f_ready_o 0, the SHLT record drains to D; a flush then clears halted_o.
REQ-038 Queue holding 2 records, rstn_i pulsed low between edges -> count_o 0 and bubble outputs before the next rising edge.
